// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcode values,
// FSM state encoding, register-file write source encoding and the opcode
// class decoder.
// Build option: CTRL_HALT_EN makes SYSTEM (1110011) a legal opcode that
// parks the controller in HALT. Without it SYSTEM is illegal.
package ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

`ifdef CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_LOAD_IR   = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM_READ  = 3'd4,
    S_MEM_WRITE = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    RD_ALU = 2'b00,
    RD_MEM = 2'b01,
    RD_PC4 = 2'b10,
    RD_IMM = 2'b11
  } rd_sel_t;

  // Where an instruction goes after EXECUTE.
  typedef enum logic [1:0] {
    K_WB    = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2,
    K_HALT  = 2'd3
  } kind_t;

  typedef struct packed {
    logic    legal;
    kind_t   kind;
    logic    op1_pc;   // 1: ALU op1 is PC
    logic    op2_imm;  // 1: ALU op2 is immediate
    rd_sel_t rd;
    logic    reg_wr;
  } ctrl_t;

  // Opcode class decoder; don't-care selects are driven 0.
  function automatic ctrl_t decode_op(input logic [6:0] op);
    ctrl_t c;
    c = '{legal: 1'b1, kind: K_WB, op1_pc: 1'b0, op2_imm: 1'b0,
          rd: RD_ALU, reg_wr: 1'b0};
    case (op)
      OP_RTYPE:  c.reg_wr = 1'b1;
      OP_IALU:   begin c.op2_imm = 1'b1; c.reg_wr = 1'b1; end
      OP_LOAD:   begin c.kind = K_LOAD; c.op2_imm = 1'b1; c.rd = RD_MEM; c.reg_wr = 1'b1; end
      OP_STORE:  begin c.kind = K_STORE; c.op2_imm = 1'b1; end
      OP_BRANCH: c.reg_wr = 1'b0;
      OP_JAL:    begin c.op1_pc = 1'b1; c.op2_imm = 1'b1; c.rd = RD_PC4; c.reg_wr = 1'b1; end
      OP_JALR:   begin c.op2_imm = 1'b1; c.rd = RD_PC4; c.reg_wr = 1'b1; end
      OP_LUI:    begin c.rd = RD_IMM; c.reg_wr = 1'b1; end
      OP_AUIPC:  begin c.op1_pc = 1'b1; c.op2_imm = 1'b1; c.reg_wr = 1'b1; end
      OP_SYSTEM: begin c.legal = HALT_EN; c.kind = K_HALT; end
      default:   c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait timer for states that must last MEM_LATENCY cycles. While en is high
// it counts the cycles of the current stay and pulses done in the last one.
// cnt_q = 0 means "first cycle of a stay"; it is reloaded with MEM_LATENCY-1
// there and counts down, so done fires when it reaches 1 (or immediately for
// a latency of one).
module mem_wait_timer #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done
);

  localparam int CW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LATENCY - 1);

  logic [CW-1:0] cnt_q;

  // Last cycle of the current stay.
  always_comb begin
    done = 1'b0;
    if (cnt_q == '0) done = en && (MEM_LATENCY == 1);
    else             done = en && (cnt_q == CW'(1));
  end

  // Down-counter, cleared whenever the waiting state is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (!en)           cnt_q <= '0;
    else if (cnt_q == '0)   cnt_q <= LOAD_VAL;
    else                    cnt_q <= cnt_q - CW'(1);
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle RV32I core. Sequences
// FETCH/LOAD_IR/DECODE/EXECUTE/MEM_READ/MEM_WRITE/WRITEBACK per instruction,
// absorbs MEM_LATENCY cycles of memory read latency and counts retired
// instructions.
// Build option: CTRL_HALT_EN (SYSTEM opcode enters a sticky HALT state).
module multi_cycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  output logic        ir_write,
  output logic        pc_write,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_addr_sel,
  output logic        alu_op1_sel,
  output logic        alu_op2_sel,
  output logic [1:0]  rd_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  logic [31:0] instret_q;
  ctrl_t       ctrl;
  logic        timer_en, timer_done;

  assign ctrl     = decode_op(opcode);
  assign timer_en = (state_q == S_FETCH) || (state_q == S_MEM_READ);
  assign state    = state_q;
  assign instret  = instret_q;

  mem_wait_timer #(.MEM_LATENCY(MEM_LATENCY)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (timer_en),
    .done (timer_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Retired-instruction counter: one per WRITEBACK or MEM_WRITE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret_q <= '0;
    else if (state_q == S_WRITEBACK || state_q == S_MEM_WRITE)
      instret_q <= instret_q + 32'd1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (timer_done) state_d = S_LOAD_IR;
      S_LOAD_IR:   state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (!ctrl.legal) state_d = S_FETCH;
        else begin
          case (ctrl.kind)
            K_LOAD:  state_d = S_MEM_READ;
            K_STORE: state_d = S_MEM_WRITE;
            K_HALT:  state_d = S_HALT;
            default: state_d = S_WRITEBACK;
          endcase
        end
      end
      S_MEM_READ:  if (timer_done) state_d = S_WRITEBACK;
      S_MEM_WRITE: state_d = S_FETCH;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
    endcase
  end

  // Moore outputs; class selects held from EXECUTE to the end of the instruction.
  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    mem_addr_sel = 1'b0;
    alu_op1_sel  = 1'b0;
    alu_op2_sel  = 1'b0;
    rd_sel       = RD_ALU;
    illegal      = 1'b0;
    if (ctrl.legal && (state_q == S_EXECUTE || state_q == S_MEM_READ ||
                       state_q == S_MEM_WRITE || state_q == S_WRITEBACK)) begin
      alu_op1_sel = ctrl.op1_pc;
      alu_op2_sel = ctrl.op2_imm;
      rd_sel      = ctrl.rd;
    end
    case (state_q)
      S_LOAD_IR:   ir_write = 1'b1;
      S_EXECUTE:   if (!ctrl.legal) begin illegal = 1'b1; pc_write = 1'b1; end
      S_MEM_READ:  mem_addr_sel = 1'b1;
      S_MEM_WRITE: begin mem_write = 1'b1; pc_write = 1'b1; end
      S_WRITEBACK: begin pc_write = 1'b1; reg_write = ctrl.reg_wr; end
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: one instance at MEM_LATENCY=1 (dut_a) and
// one at MEM_LATENCY=2 (dut_b). A table of opcode classes with hand-derived
// selects is walked cycle by cycle on both, followed by async reset, instret
// wrap and (with CTRL_HALT_EN) HALT sequences.
module tb_multi_cycle_controller;

  typedef struct packed {
    logic [2:0]  state;
    logic        ir_write;
    logic        pc_write;
    logic        mem_write;
    logic        reg_write;
    logic        mem_addr_sel;
    logic        op1;
    logic        op2;
    logic [1:0]  rd;
    logic        illegal;
    logic [31:0] instret;
  } obs_t;

  // kind: 0 = writeback path, 1 = load, 2 = store, 3 = illegal
  typedef struct {
    logic [6:0] opc;
    logic       op1;
    logic       op2;
    logic [1:0] rd;
    logic       rw;
    logic       dc_ops;
    logic       dc_rd;
    int         kind;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opc_a, opc_b;
  obs_t       obs_a, obs_b;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_inst [2];
  logic [2:0]  exp_q [$];
  vec_t        tbl [$];

  multi_cycle_controller #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .opcode(opc_a),
    .ir_write(obs_a.ir_write), .pc_write(obs_a.pc_write),
    .mem_write(obs_a.mem_write), .reg_write(obs_a.reg_write),
    .mem_addr_sel(obs_a.mem_addr_sel), .alu_op1_sel(obs_a.op1),
    .alu_op2_sel(obs_a.op2), .rd_sel(obs_a.rd), .illegal(obs_a.illegal),
    .state(obs_a.state), .instret(obs_a.instret)
  );

  multi_cycle_controller #(.MEM_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .opcode(opc_b),
    .ir_write(obs_b.ir_write), .pc_write(obs_b.pc_write),
    .mem_write(obs_b.mem_write), .reg_write(obs_b.reg_write),
    .mem_addr_sel(obs_b.mem_addr_sel), .alu_op1_sel(obs_b.op1),
    .alu_op2_sel(obs_b.op2), .rd_sel(obs_b.rd), .illegal(obs_b.illegal),
    .state(obs_b.state), .instret(obs_b.instret)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t get(input int d);
    return (d != 0) ? obs_b : obs_a;
  endfunction

  function automatic int lat(input int d);
    return (d != 0) ? 2 : 1;
  endfunction

  function automatic vec_t mk(input logic [6:0] opc, input logic op1, input logic op2,
                              input logic [1:0] rd, input logic rw, input logic dc_ops,
                              input logic dc_rd, input int kind);
    vec_t v;
    v.opc = opc; v.op1 = op1; v.op2 = op2; v.rd = rd; v.rw = rw;
    v.dc_ops = dc_ops; v.dc_rd = dc_rd; v.kind = kind;
    return v;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic set_opc(input int d, input logic [6:0] v);
    if (d != 0) opc_b = v;
    else        opc_a = v;
  endtask

  task automatic chk_quiet(input string nm, input int d);
    obs_t o;
    o = get(d);
    chk({nm, "_state"}, d, o.state, 32'd0);
    chk({nm, "_strobes"}, d, {o.ir_write, o.pc_write, o.mem_write, o.reg_write, o.illegal}, 32'd0);
    chk({nm, "_selects"}, d, {o.mem_addr_sel, o.op1, o.op2, o.rd}, 32'd0);
  endtask

  // Run an illegal instruction until its EXECUTE, leaving dut d at FETCH cycle 1.
  task automatic sync(input int d);
    obs_t o;
    bit found;
    found = 1'b0;
    set_opc(d, 7'h7F);
    for (int i = 0; i < 40 && !found; i++) begin
      o = get(d);
      if (o.state == 3'd3) found = 1'b1;
      @(negedge clk);
    end
    chk("sync", d, {31'd0, found}, 32'd1);
  endtask

  // Walk one instruction from FETCH cycle 1, checking every output each cycle.
  task automatic run_instr(input int d, input vec_t v);
    obs_t o;
    logic [2:0] s;
    bit ill, sel_on;
    ill = (v.kind == 3);
    set_opc(d, v.opc);
    exp_q.delete();
    for (int i = 0; i < lat(d); i++) exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    case (v.kind)
      0: exp_q.push_back(3'd6);
      1: begin
        for (int i = 0; i < lat(d); i++) exp_q.push_back(3'd4);
        exp_q.push_back(3'd6);
      end
      2: exp_q.push_back(3'd5);
      default: ;
    endcase
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      o = get(d);
      sel_on = (s >= 3'd3) && (s <= 3'd6);
      chk("state", d, o.state, s);
      chk("ir_write", d, o.ir_write, s == 3'd1);
      chk("pc_write", d, o.pc_write, (s == 3'd6) || (s == 3'd5) || (s == 3'd3 && ill));
      chk("mem_write", d, o.mem_write, s == 3'd5);
      chk("reg_write", d, o.reg_write, (s == 3'd6) && v.rw);
      chk("mem_addr_sel", d, o.mem_addr_sel, s == 3'd4);
      if (!v.dc_ops || !sel_on) begin
        chk("alu_op1_sel", d, o.op1, sel_on && v.op1);
        chk("alu_op2_sel", d, o.op2, sel_on && v.op2);
      end
      if (!v.dc_rd || !sel_on)
        chk("rd_sel", d, o.rd, sel_on ? v.rd : 2'b00);
      chk("illegal", d, o.illegal, (s == 3'd3) && ill);
      chk("instret", d, o.instret, exp_inst[d]);
      if (s == 3'd5 || s == 3'd6) exp_inst[d] = exp_inst[d] + 32'd1;
      @(negedge clk);
    end
    o = get(d);
    chk("end_state", d, o.state, 32'd0);
    chk("end_instret", d, o.instret, exp_inst[d]);
    set_opc(d, 7'h7F);
  endtask

  initial begin
    obs_t o;
    // Opcode classes:        opc         op1  op2  rd     rw  dcops dcrd kind
    tbl.push_back(mk(7'b0110011, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 0)); // R-type
    tbl.push_back(mk(7'b0010011, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 0)); // I-ALU
    tbl.push_back(mk(7'b0000011, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1)); // LOAD
    tbl.push_back(mk(7'b0100011, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2)); // STORE
    tbl.push_back(mk(7'b1100011, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0)); // BRANCH
    tbl.push_back(mk(7'b1101111, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 0)); // JAL
    tbl.push_back(mk(7'b1100111, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 0)); // JALR
    tbl.push_back(mk(7'b0110111, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 0)); // LUI
    tbl.push_back(mk(7'b0010111, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 0)); // AUIPC
    tbl.push_back(mk(7'b1111111, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3)); // illegal
    tbl.push_back(mk(7'b0000000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3)); // illegal
`ifndef CTRL_HALT_EN
    tbl.push_back(mk(7'b1110011, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3)); // SYSTEM
`endif

    // Reset state.
    rst = 1'b1;
    opc_a = 7'h7F;
    opc_b = 7'h7F;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_quiet("reset", d);
      o = get(d);
      chk("reset_instret", d, o.instret, 32'd0);
      exp_inst[d] = 32'd0;
    end
    rst = 1'b0;

    // Every opcode class on both latencies.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < tbl.size(); i++) begin
        sync(d);
        run_instr(d, tbl[i]);
      end

    // Asynchronous reset in the middle of MEM_READ.
    sync(1);
    set_opc(1, 7'b0000011);
    repeat (5) @(negedge clk);
    o = get(1);
    chk("pre_reset_state", 1, o.state, 32'd4);
    chk("pre_reset_addr_sel", 1, o.mem_addr_sel, 32'd1);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_quiet("async_reset", d);
      o = get(d);
      chk("async_reset_instret", d, o.instret, 32'd0);
      exp_inst[d] = 32'd0;
    end
    @(negedge clk);
    rst = 1'b0;
    set_opc(1, 7'h7F);
    // First instruction after reset starts right away in FETCH cycle 1.
    run_instr(1, tbl[0]);

    // instret wrap on LUI.
    sync(0);
    force dut_a.instret_q = 32'hFFFF_FFFF;
    #1 release dut_a.instret_q;
    exp_inst[0] = 32'hFFFF_FFFF;
    run_instr(0, tbl[7]);
    o = get(0);
    chk("instret_wrap", 0, o.instret, 32'd0);

`ifdef CTRL_HALT_EN
    // SYSTEM parks the controller in HALT with no strobes.
    sync(0);
    set_opc(0, 7'b1110011);
    for (int i = 0; i < 24; i++) begin
      o = get(0);
      chk("halt_seq_state", 0, o.state, (i < 4) ? i : 7);
      if (i >= 4) begin
        chk("halt_strobes", 0, {o.ir_write, o.pc_write, o.mem_write, o.reg_write, o.illegal}, 32'd0);
        chk("halt_instret", 0, o.instret, exp_inst[0]);
      end
      @(negedge clk);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
